// File: rtl/vc_switch_allocator_pkg.sv
// Shared flit field positions and the hop-count helper for the VC switch allocator.
package vc_switch_allocator_pkg;

  localparam int HOP_HI_BIT = 55;
  localparam int HOP_LO_BIT = 48;
  localparam int DIR_LO_BIT = 60;
  localparam int LOCAL_PORT = 0;

  // Saturating decrement: a flit that already reached hop 0 stays at 0.
  function automatic logic [63:0] hop_dec(input logic [63:0] hop);
    return (hop == 64'd0) ? 64'd0 : hop - 64'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter; the search starts at ptr and wraps, and the
// pointer moves just past the winner when update is high.
module rr_arbiter_n #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] grant
);

  localparam int PTRW = (N > 1) ? $clog2(N) : 1;

  logic [PTRW-1:0] ptr_reg;
  logic [PTRW-1:0] ptr_next;
  logic            found;
  int              idx;

  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_reg) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_next   = PTRW'((idx + 1) % N);
      end
    end
    if (!update) begin
      ptr_next = ptr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/vc_switch_allocator.sv
// Credit-based switch allocator for one virtual channel: routes each input
// flit to one output, arbitrates per output, and forwards with hop update.
module vc_switch_allocator
  import vc_switch_allocator_pkg::*;
#(
  parameter int NPORT  = 3,
  parameter int DW     = 64,
  parameter int HOP_HI = HOP_HI_BIT,
  parameter int HOP_LO = HOP_LO_BIT,
  parameter int DIR_LO = DIR_LO_BIT,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [NPORT*DW-1:0] in_data,
  input  logic [NPORT-1:0]    in_valid,
  output logic [NPORT-1:0]    in_clear,
  output logic [NPORT*DW-1:0] out_data,
  output logic [NPORT-1:0]    out_valid,
  input  logic [NPORT-1:0]    credit_ret,
  output logic                route_err,
  output logic                credit_err
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = HOP_HI - HOP_LO + 1;

  logic [NPORT-1:0][PW-1:0]    target;
  logic [NPORT-1:0]            dir_bad;
  logic [NPORT-1:0]            eligible;
  logic [NPORT-1:0]            credit_nz;
  logic [NPORT-1:0]            credit_over;
  logic [NPORT-1:0][NPORT-1:0] req_m;
  logic [NPORT-1:0][NPORT-1:0] gnt_m;
  logic [NPORT-1:0]            out_gnt;
  logic [DW-1:0]               fwd_flit [NPORT];
  logic [NPORT*DW-1:0]         out_data_reg;
  logic [NPORT-1:0]            out_valid_reg;
  logic                        route_err_reg;
  logic                        credit_err_reg;
  logic                        grant_en;

  // Reset suppresses all grants, which also keeps in_clear low.
  assign grant_en = en & ~reset;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_in
      logic [PW-1:0] dir;
      logic [HW-1:0] hop;
      assign dir          = in_data[gi*DW + DIR_LO +: PW];
      assign hop          = in_data[gi*DW + HOP_LO +: HW];
      assign dir_bad[gi]  = int'(dir) >= NPORT;
      // Only transit inputs eject on hop 0; the PE port always follows dir.
      assign target[gi]   = (gi != LOCAL_PORT && hop == '0) ? PW'(LOCAL_PORT) : dir;
      assign eligible[gi] = in_valid[gi] & ~dir_bad[gi] & credit_nz[target[gi]];
    end

    for (gi = 0; gi < NPORT; gi++) begin : g_out
      logic [CW-1:0] credit_reg;

      for (gj = 0; gj < NPORT; gj++) begin : g_req
        assign req_m[gi][gj] = grant_en & eligible[gj] & (target[gj] == PW'(gi));
      end

      rr_arbiter_n #(.N(NPORT)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_m[gi]),
        .update (grant_en),
        .grant  (gnt_m[gi])
      );

      assign out_gnt[gi]     = |gnt_m[gi];
      assign credit_nz[gi]   = credit_reg != '0;
      assign credit_over[gi] = credit_ret[gi] & ~out_gnt[gi] & (credit_reg == CW'(DEPTH));

      // A simultaneous grant and return cancel out.
      always_ff @(posedge clk) begin
        if (reset) begin
          credit_reg <= CW'(DEPTH);
        end else if (out_gnt[gi] && !credit_ret[gi]) begin
          credit_reg <= credit_reg - CW'(1);
        end else if (!out_gnt[gi] && credit_ret[gi] && !credit_over[gi]) begin
          credit_reg <= credit_reg + CW'(1);
        end
      end
    end
  endgenerate

  always_comb begin
    in_clear = '0;
    for (int o = 0; o < NPORT; o++) begin
      in_clear = in_clear | gnt_m[o];
    end
  end

  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      fwd_flit[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        if (gnt_m[o][i]) begin
          fwd_flit[o] = fwd_flit[o] | in_data[i*DW +: DW];
        end
      end
      if (o != LOCAL_PORT) begin
        fwd_flit[o][HOP_HI:HOP_LO] = HW'(hop_dec(64'(fwd_flit[o][HOP_HI:HOP_LO])));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= out_gnt;
      for (int o = 0; o < NPORT; o++) begin
        if (out_gnt[o]) begin
          out_data_reg[o*DW +: DW] <= fwd_flit[o];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      route_err_reg  <= 1'b0;
      credit_err_reg <= 1'b0;
    end else begin
      if (|(in_valid & dir_bad)) begin
        route_err_reg <= 1'b1;
      end
      if (|credit_over) begin
        credit_err_reg <= 1'b1;
      end
    end
  end

  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign route_err  = route_err_reg;
  assign credit_err = credit_err_reg;

endmodule

// File: tb/tb_vc_switch_allocator.sv
// Directed bench for vc_switch_allocator with hand-computed expectations.
module tb_vc_switch_allocator;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [191:0] in_data;
  logic [2:0]   in_valid;
  logic [2:0]   in_clear;
  logic [191:0] out_data;
  logic [2:0]   out_valid;
  logic [2:0]   credit_ret;
  logic         route_err;
  logic         credit_err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  vc_switch_allocator dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_clear   (in_clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .credit_ret (credit_ret),
    .route_err  (route_err),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [7:0] hop, input logic [1:0] dir,
                                     input logic [15:0] pay);
    logic [63:0] f;
    f        = '0;
    f[15:0]  = pay;
    f[55:48] = hop;
    f[61:60] = dir;
    return f;
  endfunction

  function automatic logic [63:0] od(input int o);
    return out_data[o*64 +: 64];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    en         = 1'b1;
    in_data    = '0;
    in_valid   = 3'b010;
    credit_ret = 3'b000;
    in_data[64 +: 64] = mk(8'd3, 2'd1, 16'hA1);

    // Reset state, with a valid request present
    #1 chk("rst_clear", in_clear, 3'b000);
    tick();
    chk("rst_out_valid", out_valid, 3'b000);
    chk("rst_out_data", out_data[63:0] | out_data[127:64] | out_data[191:128], 64'd0);
    chk("rst_route_err", route_err, 1'b0);
    chk("rst_credit_err", credit_err, 1'b0);

    // Single transit flit: same-cycle clear, forwarded one cycle later with hop-1
    reset = 1'b0;
    #1 chk("s1_clear", in_clear, 3'b010);
    tick();
    chk("s1_out_valid", out_valid, 3'b010);
    chk("s1_out_data", od(1), mk(8'd2, 2'd1, 16'hA1));

    in_valid   = 3'b000;
    credit_ret = 3'b010;
    #1 chk("s2_clear", in_clear, 3'b000);
    tick();
    chk("s2_out_valid", out_valid, 3'b000);
    chk("s2_out_hold", od(1), mk(8'd2, 2'd1, 16'hA1));
    chk("s2_credit_err", credit_err, 1'b0);

    // Two ejecting inputs alternate on output 0; credits returned each cycle
    credit_ret = 3'b001;
    in_data[64 +: 64]  = mk(8'd0, 2'd2, 16'hB1);
    in_data[128 +: 64] = mk(8'd0, 2'd1, 16'hB2);
    in_valid = 3'b110;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) credit_ret = 3'b000;
      #1;
      if (k == 6) begin
        chk("s3_stall_clear", in_clear, 3'b000);
        tick();
        chk("s3_stall_valid", out_valid, 3'b000);
        chk("s3_stall_hold", od(0), mk(8'd0, 2'd1, 16'hB2));
      end else begin
        chk($sformatf("s3_clear_%0d", k), in_clear, (k % 2 == 0) ? 3'b010 : 3'b100);
        tick();
        chk($sformatf("s3_valid_%0d", k), out_valid, 3'b001);
        chk($sformatf("s3_data_%0d", k), od(0),
            (k % 2 == 0) ? mk(8'd0, 2'd2, 16'hB1) : mk(8'd0, 2'd1, 16'hB2));
      end
    end

    // Refill output 0 to DEPTH, then one more return overflows
    in_valid   = 3'b000;
    credit_ret = 3'b001;
    tick();
    tick();
    chk("s4_err_before", credit_err, 1'b0);
    tick();
    chk("s4_err_after", credit_err, 1'b1);
    credit_ret = 3'b000;

    // Output 1 credit exhaustion: two grants, stall, return, third grant
    in_valid = 3'b001;
    in_data[63:0] = mk(8'd5, 2'd1, 16'hC0);
    #1 chk("s5_clear_a", in_clear, 3'b001);
    tick();
    chk("s5_valid_a", out_valid, 3'b010);
    chk("s5_data_a", od(1), mk(8'd4, 2'd1, 16'hC0));
    #1 chk("s5_clear_b", in_clear, 3'b001);
    tick();
    chk("s5_valid_b", out_valid, 3'b010);
    credit_ret = 3'b010;
    #1 chk("s5_clear_stall", in_clear, 3'b000);
    tick();
    chk("s5_valid_stall", out_valid, 3'b000);
    credit_ret = 3'b000;
    #1 chk("s5_clear_c", in_clear, 3'b001);
    tick();
    chk("s5_valid_c", out_valid, 3'b010);

    // Hop 0 from the PE port to a transit output saturates at 0
    in_data[63:0] = mk(8'd0, 2'd2, 16'hD0);
    #1 chk("s6_clear", in_clear, 3'b001);
    tick();
    chk("s6_valid", out_valid, 3'b100);
    chk("s6_data", od(2), mk(8'd0, 2'd2, 16'hD0));

    // Invalid direction: never cleared, sticky route_err
    in_data[63:0] = mk(8'd1, 2'd3, 16'hE0);
    #1 chk("s7_clear_bad", in_clear, 3'b000);
    chk("s7_route_err_pre", route_err, 1'b0);
    tick();
    chk("s7_route_err", route_err, 1'b1);
    chk("s7_valid_bad", out_valid, 3'b000);

    // en=0 blocks grants even with eligible requests
    en = 1'b0;
    in_data[64 +: 64]  = mk(8'd0, 2'd1, 16'hF1);
    in_data[128 +: 64] = mk(8'd0, 2'd1, 16'hF2);
    in_valid = 3'b110;
    #1 chk("s7_clear_en0", in_clear, 3'b000);
    tick();
    chk("s7_valid_en0", out_valid, 3'b000);
    chk("s7_route_sticky", route_err, 1'b1);

    // Grant moves ptr[0] to 2, then reset lands in a grant cycle
    en = 1'b1;
    in_valid = 3'b010;
    #1 chk("s8_clear_pre", in_clear, 3'b010);
    tick();
    chk("s8_valid_pre", out_valid, 3'b001);
    chk("s8_data_pre", od(0), mk(8'd0, 2'd1, 16'hF1));
    reset = 1'b1;
    in_valid = 3'b110;
    #1 chk("s8_clear_rst", in_clear, 3'b000);
    tick();
    chk("s8_valid_rst", out_valid, 3'b000);
    chk("s8_data_rst", od(0), 64'd0);
    chk("s8_route_rst", route_err, 1'b0);
    chk("s8_credit_err_rst", credit_err, 1'b0);

    // After reset ptr[0]=0 picks input 1, and output 1 has DEPTH credits again
    reset = 1'b0;
    #1 chk("s9_clear_ptr", in_clear, 3'b010);
    tick();
    chk("s9_data_ptr", od(0), mk(8'd0, 2'd1, 16'hF1));
    in_valid = 3'b001;
    in_data[63:0] = mk(8'd2, 2'd1, 16'h60);
    #1 chk("s9_clear_c1", in_clear, 3'b001);
    tick();
    #1 chk("s9_clear_c2", in_clear, 3'b001);
    tick();
    chk("s9_valid_c2", out_valid, 3'b010);
    chk("s9_data_c2", od(1), mk(8'd1, 2'd1, 16'h60));
    in_valid = 3'b000;
    #1 chk("s9_clear_idle", in_clear, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
